// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle CPU core.
// Streams a program image into instruction memory while holding the core in
// reset, then gates the core clock enable for free-run, budgeted-run and
// single-step execution, and parks the core when it retires a halt.
module cpu_run_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CYC_W  = 16
) (
  input  logic              clk,
  input  logic              areset,
  // host command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CYC_W-1:0]  cmd_arg,
  // program load stream
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  // instruction-memory write port
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  // CPU control
  output logic              cpu_rst_n,
  output logic              cpu_en,
  input  logic              cpu_halt,
  // status
  output logic [2:0]        state,
  output logic [CYC_W-1:0]  cyc_count,
  output logic              done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  state_e              state_q,  state_d;
  logic [ADDR_W-1:0]   ptr_q,    ptr_d;
  logic [CYC_W-1:0]    left_q,   left_d;
  logic [CYC_W-1:0]    cyc_q,    cyc_d;
  logic [CYC_W-1:0]    budget_q, budget_d;
  logic [CYC_W-1:0]    bcnt_q,   bcnt_d;
  logic                done_q,   done_d;

  logic                cmd_fire;
  logic                ld_fire;
  logic [CYC_W-1:0]    cyc_inc;
  logic [CYC_W-1:0]    bcnt_inc;
  logic                budget_hit;

  // Handshakes and per-cycle counter helpers
  always_comb begin
    cmd_fire   = cmd_valid & cmd_ready;
    ld_fire    = ld_valid & ld_ready;
    cyc_inc    = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
    bcnt_inc   = bcnt_q + CYC_W'(1);
    budget_hit = (budget_q != '0) && (bcnt_inc == budget_q);
  end

  // Next-state and counter update logic
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    left_d   = left_q;
    cyc_d    = cyc_q;
    budget_d = budget_q;
    bcnt_d   = bcnt_q;
    done_d   = 1'b0;

    unique case (state_q)
      // Parked states share the command decode; HALTED ignores RUN/STEP
      ST_IDLE, ST_PAUSE, ST_HALTED: begin
        if (cmd_fire) begin
          unique case (cmd_op)
            OP_LOAD: begin
              ptr_d = '0;
              cyc_d = '0;
              if (cmd_arg == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_LOAD;
                left_d  = cmd_arg;
              end
            end
            OP_RUN: begin
              if (state_q != ST_HALTED) begin
                state_d  = ST_RUN;
                budget_d = cmd_arg;
                bcnt_d   = '0;
              end
            end
            OP_STEP: begin
              if (state_q != ST_HALTED) begin
                state_d = ST_STEP;
              end
            end
            OP_STOP: begin
              if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                cyc_d   = '0;
              end
            end
            default: begin
              state_d = state_q;
            end
          endcase
        end
      end

      // One word per accepted beat; the word count, not the address, ends it
      ST_LOAD: begin
        if (ld_fire) begin
          ptr_d  = ptr_q + ADDR_W'(1);
          left_d = left_q - CYC_W'(1);
          if (left_q == CYC_W'(1)) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            cyc_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      // Halt beats budget exhaustion, which beats a host STOP
      ST_RUN: begin
        cyc_d  = cyc_inc;
        bcnt_d = bcnt_inc;
        if (cpu_halt) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (budget_hit) begin
          state_d = ST_PAUSE;
          done_d  = 1'b1;
        end else if (cmd_fire && (cmd_op == OP_STOP)) begin
          state_d = ST_PAUSE;
        end
      end

      // Single enabled cycle, then park
      ST_STEP: begin
        cyc_d   = cyc_inc;
        done_d  = 1'b1;
        state_d = cpu_halt ? ST_HALTED : ST_PAUSE;
      end

      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
        cyc_d   = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      left_q   <= '0;
      cyc_q    <= '0;
      budget_q <= '0;
      bcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      left_q   <= left_d;
      cyc_q    <= cyc_d;
      budget_q <= budget_d;
      bcnt_q   <= bcnt_d;
      done_q   <= done_d;
    end
  end

  // Control outputs decoded straight from the state register
  always_comb begin
    cpu_rst_n = 1'b1;
    cpu_en    = 1'b0;
    cmd_ready = 1'b1;
    ld_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cpu_rst_n = 1'b0;
      end
      ST_LOAD: begin
        cpu_rst_n = 1'b0;
        cmd_ready = 1'b0;
        ld_ready  = 1'b1;
      end
      ST_RUN: begin
        cpu_en = 1'b1;
      end
      ST_STEP: begin
        cpu_en    = 1'b1;
        cmd_ready = 1'b0;
      end
      ST_PAUSE, ST_HALTED: begin
        cpu_en = 1'b0;
      end
      default: begin
        cpu_rst_n = 1'b0;
      end
    endcase
  end

  // Memory write port follows the load handshake in the same cycle
  always_comb begin
    imem_we    = ld_valid & ld_ready;
    imem_addr  = ptr_q;
    imem_wdata = ld_data;
  end

  // Status outputs
  always_comb begin
    state     = state_q;
    cyc_count = cyc_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural mode/counter model.
module tb_cpu_run_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CYC_W  = 16;

  localparam bit [1:0] OP_LOAD = 2'b00;
  localparam bit [1:0] OP_RUN  = 2'b01;
  localparam bit [1:0] OP_STEP = 2'b10;
  localparam bit [1:0] OP_STOP = 2'b11;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_STEP = 3, M_PAUSE = 4, M_HALTED = 5;

  logic              clk = 1'b0;
  logic              areset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CYC_W-1:0]  cmd_arg;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rst_n;
  logic              cpu_en;
  logic              cpu_halt;
  logic [2:0]        state;
  logic [CYC_W-1:0]  cyc_count;
  logic              done;

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .cpu_halt(cpu_halt),
    .state(state), .cyc_count(cyc_count), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: operating mode plus plain integer bookkeeping
  int m_mode;
  int m_ptr;
  int m_words;
  int m_cyc;
  int m_budget;      // enabled cycles still allowed; -1 means unlimited
  bit m_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ptr = 0; m_words = 0; m_cyc = 0; m_budget = -1; m_done = 0;
  endtask

  task automatic model_idle();
    m_mode = M_IDLE; m_ptr = 0; m_cyc = 0;
  endtask

  task automatic model_step(input bit cv, input bit [1:0] op, input int arg,
                            input bit lv, input bit halt);
    bit cfire;
    bit lfire;
    cfire = cv && (m_mode != M_LOAD) && (m_mode != M_STEP);
    lfire = lv && (m_mode == M_LOAD);
    m_done = 0;
    case (m_mode)
      M_IDLE, M_PAUSE, M_HALTED: begin
        if (cfire) begin
          if (op == OP_STOP) begin
            if (m_mode != M_IDLE) model_idle();
          end else if (op == OP_LOAD) begin
            if (arg == 0) begin
              model_idle();
              m_done = 1;
            end else begin
              m_mode = M_LOAD; m_ptr = 0; m_cyc = 0; m_words = arg;
            end
          end else if (m_mode != M_HALTED) begin
            if (op == OP_RUN) begin
              m_mode = M_RUN;
              m_budget = (arg == 0) ? -1 : arg;
            end else begin
              m_mode = M_STEP;
            end
          end
        end
      end
      M_LOAD: begin
        if (lfire) begin
          m_ptr = (m_ptr + 1) % (1 << ADDR_W);
          m_words--;
          if (m_words == 0) begin
            model_idle();
            m_done = 1;
          end
        end
      end
      M_RUN: begin
        if (m_cyc < (1 << CYC_W) - 1) m_cyc++;
        if (m_budget > 0) m_budget--;
        if (halt) begin
          m_mode = M_HALTED; m_done = 1;
        end else if (m_budget == 0) begin
          m_mode = M_PAUSE; m_done = 1;
        end else if (cfire && op == OP_STOP) begin
          m_mode = M_PAUSE;
        end
      end
      M_STEP: begin
        if (m_cyc < (1 << CYC_W) - 1) m_cyc++;
        m_mode = halt ? M_HALTED : M_PAUSE;
        m_done = 1;
      end
      default: model_idle();
    endcase
  endtask

  task automatic check_outputs();
    bit exp_we;
    exp_we = ld_valid && (m_mode == M_LOAD);
    chk("state", 64'(state), 64'(m_mode));
    chk("cpu_rst_n", 64'(cpu_rst_n), 64'(m_mode >= M_RUN));
    chk("cpu_en", 64'(cpu_en), 64'(m_mode == M_RUN || m_mode == M_STEP));
    chk("cmd_ready", 64'(cmd_ready), 64'(m_mode != M_LOAD && m_mode != M_STEP));
    chk("ld_ready", 64'(ld_ready), 64'(m_mode == M_LOAD));
    chk("imem_we", 64'(imem_we), 64'(exp_we));
    chk("cyc_count", 64'(cyc_count), 64'(m_cyc));
    chk("done", 64'(done), 64'(m_done));
    if (exp_we) begin
      chk("imem_addr", 64'(imem_addr), 64'(m_ptr));
      chk("imem_wdata", 64'(imem_wdata), 64'(ld_data));
    end
  endtask

  // One clock: drive at negedge, check current outputs, advance the model
  task automatic cyc(input bit cv, input bit [1:0] op, input int arg,
                     input bit lv, input logic [31:0] data, input bit halt);
    @(negedge clk);
    cmd_valid = cv; cmd_op = op; cmd_arg = CYC_W'(arg);
    ld_valid = lv; ld_data = data; cpu_halt = halt;
    #1;
    check_outputs();
    model_step(cv, op, arg, lv, halt);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, OP_STOP, 0, 0, $urandom, 0);
  endtask

  task automatic after_edge(input string tag, input int exp_state, input int exp_cyc, input bit exp_done);
    @(posedge clk);
    #1;
    chk({tag, "_state"}, 64'(state), 64'(exp_state));
    chk({tag, "_cyc"}, 64'(cyc_count), 64'(exp_cyc));
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
  endtask

  task automatic clear_inputs();
    cmd_valid = 0; cmd_op = OP_STOP; cmd_arg = '0; ld_valid = 0; ld_data = '0; cpu_halt = 0;
  endtask

  // Asynchronous reset a few ns after the pending edge, checked before any clock
  task automatic hit_reset();
    @(posedge clk);
    #3;
    areset = 0;
    #1;
    model_reset();
    chk("rst_state", 64'(state), 64'(M_IDLE));
    chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
    chk("rst_ld_ready", 64'(ld_ready), 64'(0));
    chk("rst_imem_we", 64'(imem_we), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cyc", 64'(cyc_count), 64'(0));
    clear_inputs();
    @(negedge clk);
    areset = 1;
  endtask

  initial begin
    clear_inputs();
    areset = 0;
    model_reset();
    #12;
    chk("por_state", 64'(state), 64'(M_IDLE));
    chk("por_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("por_cpu_en", 64'(cpu_en), 64'(0));
    @(negedge clk);
    areset = 1;

    // LOAD 4 words back to back
    cyc(1, OP_LOAD, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, OP_STOP, 0, 1, 32'hA0 + 32'(i), 0);
    after_edge("load4", M_IDLE, 0, 1);

    // LOAD 3 words with 2-cycle gaps, then LOAD 0
    cyc(1, OP_LOAD, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, OP_STOP, 0, 1, $urandom, 0);
      idle_cycles(2);
    end
    cyc(1, OP_LOAD, 0, 1, $urandom, 0);
    after_edge("load0", M_IDLE, 0, 1);

    // RUN budget 5, then two steps
    cyc(1, OP_RUN, 5, 0, 0, 0);
    idle_cycles(5);
    after_edge("run5", M_PAUSE, 5, 1);
    cyc(1, OP_STEP, 0, 0, 0, 0);
    idle_cycles(1);
    after_edge("step1", M_PAUSE, 6, 1);
    cyc(1, OP_STEP, 0, 0, 0, 0);
    idle_cycles(1);
    after_edge("step2", M_PAUSE, 7, 1);
    cyc(1, OP_STOP, 0, 0, 0, 0);
    after_edge("stop_pause", M_IDLE, 0, 0);

    // Unlimited RUN; halt and STOP together on the 9th enabled cycle
    cyc(1, OP_RUN, 0, 0, 0, 0);
    idle_cycles(8);
    cyc(1, OP_STOP, 0, 0, 0, 1);
    after_edge("halt9", M_HALTED, 9, 1);
    cyc(1, OP_RUN, 3, 0, 0, 0);
    after_edge("halted_run", M_HALTED, 9, 0);
    cyc(1, OP_STOP, 0, 0, 0, 0);
    after_edge("halted_stop", M_IDLE, 0, 0);

    // Budget 3 with halt on the last budgeted cycle
    cyc(1, OP_RUN, 3, 0, 0, 0);
    idle_cycles(2);
    cyc(0, OP_STOP, 0, 0, 0, 1);
    after_edge("halt_budget", M_HALTED, 3, 1);
    idle_cycles(1);
    cyc(1, OP_STOP, 0, 0, 0, 0);

    // Reset in the middle of a 6-word load, then reload from address 0
    cyc(1, OP_LOAD, 6, 0, 0, 0);
    cyc(0, OP_STOP, 0, 1, $urandom, 0);
    cyc(0, OP_STOP, 0, 1, $urandom, 0);
    hit_reset();
    cyc(1, OP_LOAD, 2, 0, 0, 0);
    cyc(0, OP_STOP, 0, 1, 32'h1234_5678, 0);
    cyc(0, OP_STOP, 0, 1, $urandom, 0);
    idle_cycles(1);

    // Address wrap: more words than memory locations
    cyc(1, OP_LOAD, 258, 0, 0, 0);
    for (int i = 0; i < 258; i++) cyc(0, OP_STOP, 0, 1, $urandom, 0);
    after_edge("load_wrap", M_IDLE, 0, 1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      bit [1:0] op;
      int arg;
      op  = 2'($urandom_range(0, 3));
      arg = (op == OP_LOAD) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 8));
      if ($urandom_range(0, 499) == 0) hit_reset();
      cyc($urandom_range(0, 9) < 3, op, arg, $urandom_range(0, 9) < 7, $urandom,
          $urandom_range(0, 19) == 0);
    end

    idle_cycles(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
